// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA datapath constants and arbiter grant encoding
package vga_pkg;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 12;

   typedef enum logic [1:0] {
      GNT_NONE = 2'b00,
      GNT_RD   = 2'b01,
      GNT_WR   = 2'b10
   } gnt_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating count of stalled write cycles, raises force at STARVE_MAX
module arb_starve_ctr #(
   parameter int STARVE_MAX = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_wr_valid,
   input  logic i_wr_ready,
   output logic o_force
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] r_cnt;

   // A granted write (valid and ready) or an absent request restarts the count.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (!i_wr_valid || i_wr_ready) begin
         r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_force = (r_cnt == CNT_MAX);

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - pixel RAM arbiter: display reads first, writes in gaps or when starved
module vram_arbiter #(
   parameter int ADDR_W     = vga_pkg::ADDR_W,
   parameter int DATA_W     = vga_pkg::DATA_W,
   parameter int STARVE_MAX = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_blank,
   input  logic              i_disp_req,
   input  logic [ADDR_W-1:0] i_disp_addr,
   output logic [DATA_W-1:0] o_disp_data,
   output logic              o_disp_valid,
   output logic              o_disp_miss,
   output logic [15:0]       o_miss_cnt,
   input  logic              i_miss_clr,
   input  logic              i_wr_valid,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ready,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata,
   output logic              o_ram_we,
   input  logic [DATA_W-1:0] i_ram_rdata
);

   import vga_pkg::*;

   logic              w_rd_need;
   logic              w_force;
   logic              w_wr_ready;
   logic              w_grant_wr;
   logic              w_grant_rd;
   logic              w_drop;
   gnt_e              w_gnt;

   logic              r_rd_pend;
   logic              r_miss_pend;
   logic              r_disp_valid;
   logic              r_disp_miss;
   logic [DATA_W-1:0] r_disp_data;
   logic [15:0]       r_miss_cnt;

   assign w_rd_need  = i_en & i_disp_req & ~i_blank;
   assign w_wr_ready = ~w_rd_need | w_force;
   assign w_grant_wr = i_wr_valid & w_wr_ready;
   assign w_grant_rd = w_rd_need & ~w_grant_wr;
   assign w_drop     = w_rd_need & w_grant_wr;

   arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_wr_valid (i_wr_valid),
      .i_wr_ready (w_wr_ready),
      .o_force    (w_force)
   );

   always_comb begin
      w_gnt = GNT_NONE;
      if (w_grant_wr) begin
         w_gnt = GNT_WR;
      end else if (w_grant_rd) begin
         w_gnt = GNT_RD;
      end
   end

   // Idle cycles still present the display address so the RAM port never floats.
   assign o_ram_we    = (w_gnt == GNT_WR);
   assign o_ram_addr  = o_ram_we ? i_wr_addr : i_disp_addr;
   assign o_ram_wdata = i_wr_data;
   assign o_wr_ready  = w_wr_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rd_pend    <= 1'b0;
         r_miss_pend  <= 1'b0;
         r_disp_valid <= 1'b0;
         r_disp_miss  <= 1'b0;
         r_disp_data  <= '0;
         r_miss_cnt   <= '0;
      end else begin
         r_rd_pend    <= w_grant_rd;
         r_miss_pend  <= w_drop;
         r_disp_valid <= r_rd_pend;
         r_disp_miss  <= r_miss_pend;
         if (r_rd_pend) begin
            r_disp_data <= i_ram_rdata;
         end
         // Clear wins over a drop landing in the same cycle.
         if (i_miss_clr) begin
            r_miss_cnt <= '0;
         end else if (w_drop && (r_miss_cnt != 16'hFFFF)) begin
            r_miss_cnt <= r_miss_cnt + 16'd1;
         end
      end
   end

   assign o_disp_data  = r_disp_data;
   assign o_disp_valid = r_disp_valid;
   assign o_disp_miss  = r_disp_miss;
   assign o_miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed-vector bench for vram_arbiter with a behavioural pixel RAM
module tb_vram_arbiter;

   logic        clk;
   logic        rst;
   logic        en;
   logic        blank;
   logic        disp_req;
   logic [18:0] disp_addr;
   logic [11:0] disp_data;
   logic        disp_valid;
   logic        disp_miss;
   logic [15:0] miss_cnt;
   logic        miss_clr;
   logic        wr_valid;
   logic [18:0] wr_addr;
   logic [11:0] wr_data;
   logic        wr_ready;
   logic [18:0] ram_addr;
   logic [11:0] ram_wdata;
   logic        ram_we;
   logic [11:0] ram_rdata;

   int n_vec;
   int n_miss;

   logic [11:0] mem [0:(1<<19)-1];

   vram_arbiter #(
      .ADDR_W     (19),
      .DATA_W     (12),
      .STARVE_MAX (4)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_en         (en),
      .i_blank      (blank),
      .i_disp_req   (disp_req),
      .i_disp_addr  (disp_addr),
      .o_disp_data  (disp_data),
      .o_disp_valid (disp_valid),
      .o_disp_miss  (disp_miss),
      .o_miss_cnt   (miss_cnt),
      .i_miss_clr   (miss_clr),
      .i_wr_valid   (wr_valid),
      .i_wr_addr    (wr_addr),
      .i_wr_data    (wr_data),
      .o_wr_ready   (wr_ready),
      .o_ram_addr   (ram_addr),
      .o_ram_wdata  (ram_wdata),
      .o_ram_we     (ram_we),
      .i_ram_rdata  (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM, synchronous read, old data on a same-cycle read/write.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en = 1'b0; blank = 1'b0; disp_req = 1'b0; disp_addr = '0;
      miss_clr = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
   endtask

   task automatic drain();
      for (int k = 0; k < 3; k++) begin
         cyc();
         idle();
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_vec++; if (disp_data !== 12'h000) begin n_miss++; $display("FAIL reset_data got %h want 000", disp_data); end
      n_vec++; if (disp_valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid got %b want 0", disp_valid); end
      n_vec++; if (disp_miss !== 1'b0) begin n_miss++; $display("FAIL reset_miss got %b want 0", disp_miss); end
      n_vec++; if (miss_cnt !== 16'h0000) begin n_miss++; $display("FAIL reset_cnt got %h want 0000", miss_cnt); end
      n_vec++; if (wr_ready !== 1'b1) begin n_miss++; $display("FAIL reset_ready_idle got %b want 1", wr_ready); end
      n_vec++; if (ram_we !== 1'b0) begin n_miss++; $display("FAIL reset_we got %b want 0", ram_we); end
      en = 1'b1; disp_req = 1'b1; disp_addr = 19'h00123;
      #1;
      n_vec++; if (wr_ready !== 1'b0) begin n_miss++; $display("FAIL reset_ready_need got %b want 0", wr_ready); end
      n_vec++; if (ram_addr !== 19'h00123) begin n_miss++; $display("FAIL reset_ram_addr got %h want 00123", ram_addr); end
      idle();
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reads();
      logic exp_v;
      for (int c = 0; c < 13; c++) begin
         cyc();
         en = 1'b1; blank = 1'b0; wr_valid = 1'b0;
         disp_req = (c < 10); disp_addr = 19'(c);
         @(negedge clk);
         exp_v = (c >= 2 && c <= 11);
         n_vec++; if (disp_valid !== exp_v) begin n_miss++; $display("FAIL reads_valid c=%0d got %b want %b", c, disp_valid, exp_v); end
         if (exp_v) begin
            n_vec++; if (disp_data !== 12'(c - 2)) begin n_miss++; $display("FAIL reads_data c=%0d got %h want %h", c, disp_data, 12'(c - 2)); end
         end
         n_vec++; if (wr_ready !== (c >= 10)) begin n_miss++; $display("FAIL reads_ready c=%0d got %b want %b", c, wr_ready, (c >= 10)); end
      end
      drain();
   endtask

   task automatic test_idle_writes();
      logic exp_v;
      for (int c = 0; c < 9; c++) begin
         cyc();
         en = 1'b1; disp_req = 1'b1;
         blank = (c < 3);
         disp_addr = (c < 3) ? 19'd0 : 19'(5 + c - 3);
         if (c >= 6) disp_req = 1'b0;
         wr_valid = (c < 3); wr_addr = 19'(5 + c); wr_data = 12'hA05 + 12'(c);
         @(negedge clk);
         if (c < 4) begin
            n_vec++; if (ram_we !== (c < 3)) begin n_miss++; $display("FAIL idle_we c=%0d got %b want %b", c, ram_we, (c < 3)); end
         end
         if (c < 3) begin
            n_vec++; if (wr_ready !== 1'b1) begin n_miss++; $display("FAIL idle_ready c=%0d got %b want 1", c, wr_ready); end
            n_vec++; if (ram_addr !== 19'(5 + c)) begin n_miss++; $display("FAIL idle_addr c=%0d got %h want %h", c, ram_addr, 19'(5 + c)); end
            n_vec++; if (ram_wdata !== 12'hA05 + 12'(c)) begin n_miss++; $display("FAIL idle_wdata c=%0d got %h want %h", c, ram_wdata, 12'hA05 + 12'(c)); end
         end
         exp_v = (c >= 5 && c <= 7);
         n_vec++; if (disp_valid !== exp_v) begin n_miss++; $display("FAIL idle_valid c=%0d got %b want %b", c, disp_valid, exp_v); end
         if (exp_v) begin
            n_vec++; if (disp_data !== 12'hA05 + 12'(c - 5)) begin n_miss++; $display("FAIL idle_readback c=%0d got %h want %h", c, disp_data, 12'hA05 + 12'(c - 5)); end
         end
      end
      drain();
   endtask

   task automatic test_starve();
      logic        exp_w;
      logic        exp_v;
      logic        exp_m;
      logic [15:0] exp_cnt;
      for (int c = 0; c < 12; c++) begin
         cyc();
         en = 1'b1; blank = 1'b0; disp_req = 1'b1; disp_addr = 19'(20 + c);
         wr_valid = 1'b1; wr_addr = 19'd40; wr_data = 12'h5A5;
         @(negedge clk);
         exp_w   = (c == 4 || c == 9);
         exp_m   = (c == 6 || c == 11);
         exp_v   = (c >= 2) && !exp_m;
         exp_cnt = (c < 5) ? 16'd0 : (c < 10) ? 16'd1 : 16'd2;
         n_vec++; if (wr_ready !== exp_w) begin n_miss++; $display("FAIL starve_ready c=%0d got %b want %b", c, wr_ready, exp_w); end
         n_vec++; if (ram_we !== exp_w) begin n_miss++; $display("FAIL starve_we c=%0d got %b want %b", c, ram_we, exp_w); end
         n_vec++; if (disp_miss !== exp_m) begin n_miss++; $display("FAIL starve_miss c=%0d got %b want %b", c, disp_miss, exp_m); end
         n_vec++; if (disp_valid !== exp_v) begin n_miss++; $display("FAIL starve_valid c=%0d got %b want %b", c, disp_valid, exp_v); end
         if (exp_v) begin
            n_vec++; if (disp_data !== 12'(18 + c)) begin n_miss++; $display("FAIL starve_data c=%0d got %h want %h", c, disp_data, 12'(18 + c)); end
         end
         n_vec++; if (miss_cnt !== exp_cnt) begin n_miss++; $display("FAIL starve_cnt c=%0d got %h want %h", c, miss_cnt, exp_cnt); end
      end
      drain();
   endtask

   task automatic test_hazard();
      for (int c = 0; c < 8; c++) begin
         cyc();
         en = 1'b1; blank = 1'b0; disp_req = (c < 6);
         disp_addr = (c < 3) ? 19'(10 + c) : 19'd3;
         wr_valid = (c <= 4); wr_addr = 19'd3; wr_data = 12'h3C3;
         @(negedge clk);
         if (c == 4) begin
            n_vec++; if (ram_we !== 1'b1 || ram_addr !== 19'd3) begin n_miss++; $display("FAIL hazard_write we=%b addr=%h want we=1 addr=00003", ram_we, ram_addr); end
         end
         if (c == 5) begin
            n_vec++; if (disp_valid !== 1'b1 || disp_data !== 12'h003) begin n_miss++; $display("FAIL hazard_old valid=%b data=%h want 1/003", disp_valid, disp_data); end
         end
         if (c == 6) begin
            n_vec++; if (disp_miss !== 1'b1 || disp_valid !== 1'b0) begin n_miss++; $display("FAIL hazard_drop miss=%b valid=%b want 1/0", disp_miss, disp_valid); end
         end
         if (c == 7) begin
            n_vec++; if (disp_valid !== 1'b1 || disp_data !== 12'h3C3) begin n_miss++; $display("FAIL hazard_new valid=%b data=%h want 1/3c3", disp_valid, disp_data); end
         end
      end
      drain();
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 8; c++) begin
         cyc();
         en = 1'b1; blank = 1'b0; disp_req = 1'b1; disp_addr = 19'(30 + c); wr_valid = 1'b0;
         rst = (c == 3 || c == 4);
         @(negedge clk);
         if (c == 2) begin
            n_vec++; if (disp_valid !== 1'b1 || disp_data !== 12'd30) begin n_miss++; $display("FAIL rstmid_pre valid=%b data=%h want 1/01e", disp_valid, disp_data); end
         end
         if (c == 3 || c == 4) begin
            n_vec++; if (disp_valid !== 1'b0 || disp_miss !== 1'b0) begin n_miss++; $display("FAIL rstmid_flags c=%0d valid=%b miss=%b want 0/0", c, disp_valid, disp_miss); end
            n_vec++; if (disp_data !== 12'h000 || miss_cnt !== 16'h0000) begin n_miss++; $display("FAIL rstmid_regs c=%0d data=%h cnt=%h want 000/0000", c, disp_data, miss_cnt); end
            n_vec++; if (wr_ready !== 1'b0 || ram_we !== 1'b0) begin n_miss++; $display("FAIL rstmid_comb c=%0d ready=%b we=%b want 0/0", c, wr_ready, ram_we); end
         end
         if (c == 5 || c == 6) begin
            n_vec++; if (disp_valid !== 1'b0) begin n_miss++; $display("FAIL rstmid_early c=%0d got %b want 0", c, disp_valid); end
         end
         if (c == 7) begin
            n_vec++; if (disp_valid !== 1'b1 || disp_data !== 12'd35) begin n_miss++; $display("FAIL rstmid_first valid=%b data=%h want 1/023", disp_valid, disp_data); end
         end
      end
      drain();
   endtask

   task automatic test_saturation();
      logic [15:0] exp_cnt;
      @(negedge clk);
      force dut.r_miss_cnt = 16'hFFFE;
      #1;
      release dut.r_miss_cnt;
      for (int c = 0; c < 16; c++) begin
         cyc();
         en = 1'b1; blank = 1'b0; disp_req = 1'b1; disp_addr = 19'(c);
         wr_valid = 1'b1; wr_addr = 19'd50; wr_data = 12'h777;
         miss_clr = (c == 14);
         @(negedge clk);
         exp_cnt = (c < 5) ? 16'hFFFE : (c < 15) ? 16'hFFFF : 16'h0000;
         n_vec++; if (miss_cnt !== exp_cnt) begin n_miss++; $display("FAIL sat_cnt c=%0d got %h want %h", c, miss_cnt, exp_cnt); end
         if (c == 14) begin
            n_vec++; if (wr_ready !== 1'b1) begin n_miss++; $display("FAIL sat_force got %b want 1", wr_ready); end
         end
      end
      drain();
   endtask

   initial begin
      n_vec = 0;
      n_miss = 0;
      for (int i = 0; i < 64; i++) mem[i] = 12'(i);
      rst = 1'b1;
      idle();
      test_reset();
      test_reads();
      test_idle_writes();
      test_starve();
      test_hazard();
      test_reset_mid();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
